// File: rtl/ram_access_pkg.sv
// Shared types and encodings for the data-RAM access unit.
package ram_access_pkg;
  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;
endpackage

// File: rtl/ram_lane_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge
// and alignment check for a little-endian word-only RAM.
module ram_lane_align
  import ram_access_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic [1:0]            i_adr_lo,
  input  logic [1:0]            i_size,
  input  logic                  i_signed,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [DATA_WIDTH-1:0] o_merged,
  output logic                  o_misalign
);
  logic [4:0]  w_bsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_bsh  = {i_adr_lo, 3'b000};
  assign w_byte = i_word[w_bsh +: 8];
  assign w_half = i_adr_lo[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_rdata    = '0;
    o_merged   = i_word;
    o_misalign = 1'b0;
    case (i_size)
      SIZE_BYTE: begin
        o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
        o_merged[w_bsh +: 8] = i_wdata[7:0];
      end
      SIZE_HALF: begin
        o_rdata = {{16{i_signed & w_half[15]}}, w_half};
        if (i_adr_lo[1]) o_merged[31:16] = i_wdata[15:0];
        else             o_merged[15:0]  = i_wdata[15:0];
        o_misalign = i_adr_lo[0];
      end
      SIZE_WORD: begin
        o_rdata    = i_word;
        o_merged   = i_wdata;
        o_misalign = |i_adr_lo;
      end
      default: o_misalign = 1'b1;  // size 11 is illegal
    endcase
  end
endmodule

// File: rtl/ram_access_unit.sv
// Load/store initiator for a word-only data RAM: one request in flight,
// read-modify-write for sub-word stores, one-cycle response pulse.
module ram_access_unit
  import ram_access_pkg::*;
#(
  parameter int ADDR_BITS  = 32,
  parameter int DATA_WIDTH = ram_access_pkg::DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_signed,
  input  logic [ADDR_BITS-1:0]  i_req_adr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_mem_we,
  output logic [ADDR_BITS-1:0]  o_mem_adr,
  output logic [DATA_WIDTH-1:0] o_mem_din,
  input  logic [DATA_WIDTH-1:0] i_mem_dout
);
  state_t                r_state;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [1:0]            r_adr_lo;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  r_mem_we;
  logic [ADDR_BITS-1:0]  r_mem_adr;
  logic [DATA_WIDTH-1:0] r_mem_din;

  logic                  w_idle;
  logic [1:0]            w_adr_lo;
  logic [1:0]            w_size;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_misalign;

  assign w_idle = (r_state == S_IDLE);
  // The align check runs on the live request while idle; extraction and merge
  // always run on the latched fields.
  assign w_adr_lo = w_idle ? i_req_adr[1:0] : r_adr_lo;
  assign w_size   = w_idle ? i_req_size     : r_size;

  ram_lane_align u_align (
    .i_word     (i_mem_dout),
    .i_adr_lo   (w_adr_lo),
    .i_size     (w_size),
    .i_signed   (r_signed),
    .i_wdata    (r_wdata),
    .o_rdata    (w_rdata),
    .o_merged   (w_merged),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_size      <= SIZE_BYTE;
      r_signed    <= 1'b0;
      r_adr_lo    <= 2'b00;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_adr   <= '0;
      r_mem_din   <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      case (r_state)
        S_IDLE: if (i_req_valid) begin
          r_we     <= i_req_we;
          r_size   <= i_req_size;
          r_signed <= i_req_signed;
          r_adr_lo <= i_req_adr[1:0];
          r_wdata  <= i_req_wdata;
          if (w_misalign) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= S_RESP;
          end else begin
            r_mem_adr <= {i_req_adr[ADDR_BITS-1:2], 2'b00};
            if (i_req_we && i_req_size == SIZE_WORD) begin
              r_mem_din <= i_req_wdata;
              r_mem_we  <= 1'b1;
              r_state   <= S_WRITE;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (r_we) begin
            r_mem_din <= w_merged;
            r_mem_we  <= 1'b1;
            r_state   <= S_WRITE;
          end else begin
            r_rsp_rdata <= w_rdata;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_WRITE: begin
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready = w_idle;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_mem_we    = r_mem_we;
  assign o_mem_adr   = r_mem_adr;
  assign o_mem_din   = r_mem_din;
endmodule

// File: tb/tb_ram_access_unit.sv
// Directed bench for ram_access_unit with a word-array RAM and a reference
// memory model that predicts responses, writes and latencies.
module tb_ram_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_adr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_we;
  logic [31:0] rsp_rdata, mem_adr, mem_din, mem_dout;

  logic [31:0] ram [64];
  logic [31:0] ref_mem [64];
  logic [31:0] q_rdata[$], q_wadr[$], q_wdat[$];
  bit          q_err[$];
  int          n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  ram_access_unit #(.ADDR_BITS(32), .DATA_WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_size(req_size), .i_req_signed(req_signed),
    .i_req_adr(req_adr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_mem_we(mem_we), .o_mem_adr(mem_adr), .o_mem_din(mem_din),
    .i_mem_dout(mem_dout)
  );

  assign mem_dout = ram[mem_adr[7:2]];
  always @(posedge clk) if (mem_we) ram[mem_adr[7:2]] <= mem_din;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Every cycle: any response or RAM write must match the next predicted one.
  always @(negedge clk) if (rst_n) begin
    if (rsp_valid) begin
      if (q_rdata.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else begin
        check("rsp_rdata", rsp_rdata, q_rdata.pop_front());
        check("rsp_err", {31'd0, rsp_err}, {31'd0, q_err.pop_front()});
      end
    end
    if (mem_we) begin
      if (q_wadr.size() == 0) check("write_unexpected", mem_adr, 32'hFFFF_FFFF);
      else begin
        check("write_adr", mem_adr, q_wadr.pop_front());
        check("write_din", mem_din, q_wdat.pop_front());
      end
    end
  end

  task automatic do_req(input string nm, input bit we, input logic [1:0] sz, input bit sg,
                        input logic [31:0] adr, input logic [31:0] wd);
    logic [31:0] w, v, er, nw;
    bit          ee;
    int          idx, sh, el, ewe, lat, nwe;
    idx = int'(adr[7:2]);
    w   = ref_mem[idx];
    ee  = (sz == 2'b11) || (sz == 2'b01 && adr[0]) || (sz == 2'b10 && adr[1:0] != 2'b00);
    er  = 32'd0;
    ewe = 0;
    if (ee) el = 1;
    else if (!we) begin
      el = 2;
      if (sz == 2'b00) begin
        v = (w >> (8 * int'(adr[1:0]))) & 32'hFF;
        if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
        v = (w >> (16 * int'(adr[1]))) & 32'hFFFF;
        if (sg && v[15]) v = v | 32'hFFFF_0000;
      end else v = w;
      er = v;
    end else begin
      ewe = 1;
      if (sz == 2'b10) begin el = 2; nw = wd; end
      else if (sz == 2'b00) begin
        el = 3; sh = 8 * int'(adr[1:0]);
        nw = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      end else begin
        el = 3; sh = 16 * int'(adr[1]);
        nw = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      end
      ref_mem[idx] = nw;
      q_wadr.push_back({adr[31:2], 2'b00});
      q_wdat.push_back(nw);
    end
    q_rdata.push_back(er);
    q_err.push_back(ee);

    @(negedge clk);
    check({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_adr = adr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = 2'($urandom);
    req_signed = $urandom_range(0, 1); req_adr = $urandom; req_wdata = $urandom;
    lat = 0; nwe = 0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      if (n == 1 && !ee) check({nm, "_mem_adr"}, mem_adr, {adr[31:2], 2'b00});
      if (n == 1) check({nm, "_busy"}, {31'd0, req_ready}, 32'd0);
      if (mem_we) nwe++;
      if (rsp_valid) lat = n;
      else @(posedge clk);
    end
    check({nm, "_latency"}, lat, el);
    check({nm, "_we_pulses"}, nwe, ewe);
    check({nm, "_ram_word"}, ram[idx], ref_mem[idx]);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i] = 32'h0101_0101 * i;
      ref_mem[i] = 32'h0101_0101 * i;
    end
    ram[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;

    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      req_valid = $urandom_range(0, 1); req_we = $urandom_range(0, 1);
      req_size = 2'($urandom); req_adr = $urandom; req_wdata = $urandom;
      #1;
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_outs", {rsp_err, mem_we, 30'd0} | rsp_rdata | mem_adr | mem_din, 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst_we", {31'd0, mem_we}, 32'd0);

    do_req("lw",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lit_lw", rsp_rdata, 32'hDEAD_BEEF);
    do_req("lb",  1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check("lit_lb", rsp_rdata, 32'hFFFF_FFDE);
    do_req("lbu", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("lit_lbu", rsp_rdata, 32'h0000_00DE);
    do_req("lh",  1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    check("lit_lh", rsp_rdata, 32'hFFFF_BEEF);
    do_req("lhu", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    check("lit_lhu", rsp_rdata, 32'h0000_DEAD);
    do_req("lbu1", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0);

    do_req("sh",  1'b1, 2'b01, 1'b0, 32'h12, 32'hAAAA_1234);
    check("lit_sh_ram", ram[4], 32'h1234_BEEF);
    do_req("lw2", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lit_lw2", rsp_rdata, 32'h1234_BEEF);
    do_req("sw",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    do_req("sb",  1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FF55);
    check("lit_sb_ram", ram[4], 32'hDEAD_55EF);

    do_req("err_sw",  1'b1, 2'b10, 1'b0, 32'h21, 32'h1111_1111);
    check("lit_err_flag", {31'd0, rsp_err}, 32'd1);
    check("lit_err_rdata", rsp_rdata, 32'd0);
    do_req("err_lh",  1'b0, 2'b01, 1'b1, 32'h11, 32'h0);
    do_req("err_sz",  1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    check("lit_err_ram", ram[8], 32'h0808_0808);

    do_req("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h600D_F00D);
    check("lit_sw_rdata", rsp_rdata, 32'd0);
    do_req("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

    // Abort a word store while its write strobe is up.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_adr = 32'h10; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("mid_we_high", {31'd0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check("mid_we_drop", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_ram_kept", ram[4], 32'hDEAD_55EF);
    @(negedge clk);
    check("mid_ready", {31'd0, req_ready}, 32'd1);
    do_req("lw_after", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lit_lw_after", rsp_rdata, 32'hDEAD_55EF);

    repeat (2) @(negedge clk);
    check("rsp_queue_drained", q_rdata.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
